// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared markers, FSM encoding and address helper for instr_mem_stream
// Contents:
//   START/END/ESC   loader framing bytes
//   state_t         loader FSM state encoding
//   addr_to_index   byte address to word index
package instr_mem_pkg;

  localparam logic [7:0] START = 8'hFE;
  localparam logic [7:0] END   = 8'hFF;
  localparam logic [7:0] ESC   = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ESC   = 2'd3
  } state_t;

  // Callers zero-extend their address to 64 bits so one helper serves any ADDR_W.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/instr_mem_stream_assembler.sv
// rtl/instr_mem_stream_assembler.sv - packs loader data bytes into words, flushes partial words
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             drop any partly assembled word (load restart)
//   data_valid        data_byte is an accepted payload byte
//   data_byte         payload byte
//   flush             END accepted; emit a partly filled word if any
//   word_valid        word is complete and must be written this edge
//   word              assembled word, current byte already merged in
//   partial           the word being emitted is a flushed partial word
module instr_word_assembler #(
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    data_valid,
  input  logic [7:0]              data_byte,
  input  logic                    flush,
  output logic                    word_valid,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    partial
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] merged;
  logic              last_lane;

  // acc is zeroed after every emitted word, so unfilled lanes of a flushed word read as 0.
  always_comb begin
    merged = acc;
    if (data_valid) begin
      if (BIG_ENDIAN != 0) merged[8*(WORD_BYTES-1-int'(lane)) +: 8] = data_byte;
      else                 merged[8*int'(lane) +: 8]                = data_byte;
    end
  end

  assign last_lane  = (lane == LANE_W'(WORD_BYTES - 1));
  assign partial    = flush && (lane != '0);
  assign word_valid = (data_valid && last_lane) || partial;
  assign word       = merged;

  always_ff @(posedge clk) begin
    if (reset || clear || word_valid) begin
      acc  <= '0;
      lane <= '0;
    end else if (data_valid) begin
      acc  <= merged;
      lane <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_stream.sv
// rtl/instr_mem_stream.sv - instruction memory loaded by a framed, escaped byte stream
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_byte  loader byte stream, accepted when in_valid && in_ready
//   in_ready          low only while the clear sweep runs
//   rd_addr/rd_data   combinational fetch by byte address; 0 beyond DEPTH
//   loading           loader is not idle
//   load_done         one-cycle pulse after END is accepted
//   word_count        words written in the current or last load
//   err_overflow      sticky: a word arrived with the memory already full
//   err_partial       sticky: END arrived mid-word
module instr_mem_stream
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 64,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [8*WORD_BYTES-1:0]    rd_data,
  output logic                       loading,
  output logic                       load_done,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       err_overflow,
  output logic                       err_partial
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHIFT  = $clog2(WORD_BYTES);

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept;
  logic              is_marker;
  logic              data_valid;
  logic              flush;
  logic              restart;
  logic              room;
  logic              asm_word_valid;
  logic              asm_partial;
  logic [WORD_W-1:0] asm_word;
  logic [63:0]       rd_idx;

  assign accept    = in_valid && in_ready;
  assign is_marker = (in_byte == START) || (in_byte == END) || (in_byte == ESC);
  // In ESC every byte is payload, including the marker values.
  assign data_valid = accept && (((state == ST_LOAD) && !is_marker) || (state == ST_ESC));
  assign flush      = accept && (state == ST_LOAD) && (in_byte == END);
  assign restart    = accept && (in_byte == START) && ((state == ST_IDLE) || (state == ST_LOAD));
  // word_count doubles as the write pointer: both advance only on a stored word.
  assign room       = word_count < CNT_W'(DEPTH);

  instr_word_assembler #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .data_valid (data_valid),
    .data_byte  (in_byte),
    .flush      (flush),
    .word_valid (asm_word_valid),
    .word       (asm_word),
    .partial    (asm_partial)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b1;
      loading      <= 1'b0;
      load_done    <= 1'b0;
      clr_idx      <= '0;
      word_count   <= '0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (asm_word_valid) begin
        if (room) word_count   <= word_count + CNT_W'(1);
        else      err_overflow <= 1'b1;
      end
      if (asm_partial) err_partial <= 1'b1;

      // restart is placed after the word bookkeeping so its clears take priority.
      if (restart) begin
        state        <= ST_CLEAR;
        in_ready     <= 1'b0;
        loading      <= 1'b1;
        clr_idx      <= '0;
        word_count   <= '0;
        err_overflow <= 1'b0;
        err_partial  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_CLEAR: begin
            if (clr_idx == IDX_W'(DEPTH - 1)) begin
              state    <= ST_LOAD;
              in_ready <= 1'b1;
            end else begin
              clr_idx <= clr_idx + IDX_W'(1);
            end
          end
          ST_LOAD: begin
            if (flush) begin
              state     <= ST_IDLE;
              loading   <= 1'b0;
              load_done <= 1'b1;
            end else if (accept && (in_byte == ESC)) begin
              state <= ST_ESC;
            end
          end
          ST_ESC: begin
            if (accept) state <= ST_LOAD;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sweep writes and stream writes never coincide: in_ready is low during the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (asm_word_valid && room) begin
      mem[word_count[IDX_W-1:0]] <= asm_word;
    end
  end

  assign rd_idx  = addr_to_index(64'(rd_addr), SHIFT);
  assign rd_data = (rd_idx < 64'(DEPTH)) ? mem[rd_idx[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_instr_mem_stream.sv
// tb/tb_instr_mem_stream.sv - self-checking bench for instr_mem_stream (default and small LE instances)
module tb_instr_mem_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // dut0: defaults (DEPTH=64, big endian); dut1: DEPTH=4, little endian
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [7:0]  b0 = 8'h00, b1 = 8'h00;
  logic        r0, r1;
  logic [31:0] a0 = '0, a1 = '0;
  logic [31:0] d0, d1;
  logic        ld0, ld1, done0, done1, ov0, ov1, pa0, pa1;
  logic [6:0]  wc0;
  logic [2:0]  wc1;

  instr_mem_stream u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_byte(b0), .in_ready(r0),
    .rd_addr(a0), .rd_data(d0), .loading(ld0), .load_done(done0),
    .word_count(wc0), .err_overflow(ov0), .err_partial(pa0)
  );

  instr_mem_stream #(.DEPTH(4), .BIG_ENDIAN(0)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_byte(b1), .in_ready(r1),
    .rd_addr(a1), .rd_data(d1), .loading(ld1), .load_done(done1),
    .word_count(wc1), .err_overflow(ov1), .err_partial(pa1)
  );

  int errors = 0;
  int checks = 0;
  int dn0 = 0, dn1 = 0;

  always @(negedge clk) begin
    if (done0 === 1'b1) dn0++;
    if (done1 === 1'b1) dn1++;
  end

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int d, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (d == 0) begin v0 = 1'b1; b0 = b; end
    else        begin v1 = 1'b1; b1 = b; end
    while (((d == 0) ? r0 : r1) !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout dut=%0d byte=%h waited=%0d required<200", d, b, n);
    end
    @(posedge clk); #1;
    if (d == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic send_seq(input int d, input logic [7:0] s[$]);
    foreach (s[i]) send(d, s[i]);
  endtask

  task automatic read_word(input int d, input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    if (d == 0) a0 = addr; else a1 = addr;
    #1;
    data = (d == 0) ? d0 : d1;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    do_reset();
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", r0); end
    checks++; if (ld0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_flags loading=%b done=%b exp=0,0", ld0, done0); end
    checks++; if (wc0 !== 7'd0) begin errors++; $display("FAIL reset_wc got=%0d exp=0", wc0); end
    checks++; if (ov0 !== 1'b0 || pa0 !== 1'b0) begin errors++; $display("FAIL reset_err ov=%b pa=%b exp=0,0", ov0, pa0); end
    checks++; if (r1 !== 1'b1 || ld1 !== 1'b0 || wc1 !== 3'd0) begin errors++; $display("FAIL reset_dut1 ready=%b loading=%b wc=%0d exp=1,0,0", r1, ld1, wc1); end
    q.push_back('{0, 32'h0, 32'h0});
    q.push_back('{1, 32'hC, 32'h0});
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL reset_mem dut=%0d addr=%h got=%h exp=%h", e.d, e.addr, got, e.data); end
    end
  endtask

  task automatic test_basic();
    exp_t e; logic [31:0] got; int start = dn0;
    send_seq(0, '{8'hFE, 8'h00, 8'h11, 8'h22, 8'h33, 8'hFF});
    q.push_back('{0, 32'h0, 32'h00112233});
    checks++; if (done0 !== 1'b1 || ld0 !== 1'b0) begin errors++; $display("FAIL basic_done_now done=%b loading=%b exp=1,0", done0, ld0); end
    checks++; if (wc0 !== 7'd1) begin errors++; $display("FAIL basic_wc got=%0d exp=1", wc0); end
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL basic_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
    checks++; if (dn0 - start !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dn0 - start); end
  endtask

  task automatic test_escape();
    exp_t e; logic [31:0] got;
    send_seq(0, '{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h44, 8'hFF});
    q.push_back('{0, 32'h0, 32'hFFFEFD44});
    q.push_back('{0, 32'h4, 32'h0});
    checks++; if (ov0 !== 1'b0 || pa0 !== 1'b0 || wc0 !== 7'd1) begin errors++; $display("FAIL esc_status ov=%b pa=%b wc=%0d exp=0,0,1", ov0, pa0, wc0); end
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL esc_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_little_endian();
    exp_t e; logic [31:0] got;
    send_seq(1, '{8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    q.push_back('{1, 32'h0, 32'h44332211});
    checks++; if (wc1 !== 3'd1) begin errors++; $display("FAIL le_wc got=%0d exp=1", wc1); end
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL le_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_overflow();
    exp_t e; logic [31:0] got; logic [7:0] bt [4];
    send(1, 8'hFE);
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        bt[j] = 8'(16 * k + j + 1);
        send(1, bt[j]);
      end
      if (k <= 4) q.push_back('{1, 32'(4 * (k - 1)), {bt[3], bt[2], bt[1], bt[0]}});
    end
    q.push_back('{1, 32'h10, 32'h0});
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ov1); end
    checks++; if (wc1 !== 3'd4) begin errors++; $display("FAIL ovf_wc got=%0d exp=4", wc1); end
    send(1, 8'hFF);
    checks++; if (pa1 !== 1'b0 || ov1 !== 1'b1 || ld1 !== 1'b0) begin errors++; $display("FAIL ovf_end pa=%b ov=%b loading=%b exp=0,1,0", pa1, ov1, ld1); end
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL ovf_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_partial_restart();
    exp_t e; logic [31:0] got; int n = 0; logic saw_loading;
    send_seq(0, '{8'hFE, 8'hAA, 8'hBB, 8'hFF});
    q.push_back('{0, 32'h0, 32'hAABB0000});
    checks++; if (pa0 !== 1'b1 || ov0 !== 1'b0) begin errors++; $display("FAIL part_err pa=%b ov=%b exp=1,0", pa0, ov0); end
    checks++; if (wc0 !== 7'd1) begin errors++; $display("FAIL part_wc got=%0d exp=1", wc0); end
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL part_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
    send(0, 8'hFE);
    saw_loading = ld0;
    checks++; if (pa0 !== 1'b0 || ov0 !== 1'b0 || wc0 !== 7'd0) begin errors++; $display("FAIL restart_clear pa=%b ov=%b wc=%0d exp=0,0,0", pa0, ov0, wc0); end
    while (r0 !== 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    checks++; if (n !== 64) begin errors++; $display("FAIL restart_ready_low cycles=%0d exp=64", n); end
    checks++; if (saw_loading !== 1'b1) begin errors++; $display("FAIL restart_loading got=%b exp=1", saw_loading); end
    q.push_back('{0, 32'h0, 32'h0});
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL restart_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
    send(0, 8'hFF);
    checks++; if (pa0 !== 1'b0 || ld0 !== 1'b0) begin errors++; $display("FAIL restart_end pa=%b loading=%b exp=0,0", pa0, ld0); end
  endtask

  task automatic test_reset_midload();
    exp_t e; logic [31:0] got;
    send_seq(0, '{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    q.push_back('{0, 32'h0, 32'h01020304});
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL midload_pre addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
    do_reset();
    checks++; if (ld0 !== 1'b0 || r0 !== 1'b1 || wc0 !== 7'd0) begin errors++; $display("FAIL midload_state loading=%b ready=%b wc=%0d exp=0,1,0", ld0, r0, wc0); end
    q.push_back('{0, 32'h0, 32'h0});
    q.push_back('{0, 32'h4, 32'h0});
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL midload_mem addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
    send_seq(0, '{8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF});
    q.push_back('{0, 32'h0, 32'h0A0B0C0D});
    q.push_back('{0, 32'h4, 32'h0});
    while (q.size() > 0) begin
      e = q.pop_front(); read_word(e.d, e.addr, got);
      checks++; if (got !== e.data) begin errors++; $display("FAIL midload_reload addr=%h got=%h exp=%h", e.addr, got, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_little_endian();
    test_overflow();
    test_partial_restart();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
